start_conditioner: RTL and testbench

Input front-end for the factorial-sum datapath. Synchronizes and debounces the raw start push-button and the 6-bit `num` switches. On each clean press it range-checks the switch value, latches it as `target`, and issues a one-cycle `start_pulse` to the downstream compute FSM. It then tracks that FSM's `busy` handshake so that presses cannot re-trigger a computation in flight.

---
 rtl/start_conditioner.sv | 192 +++++++++++++++++++
 tb/tb_start_conditioner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/start_conditioner.sv
// start_conditioner: input front-end for the factorial-sum datapath.
// Synchronizes and debounces the start button and the num switches, range
// checks the switch value on each clean press, hands a one-cycle start pulse
// to the compute FSM and follows its busy handshake so presses cannot
// re-trigger a computation that is still running.
module start_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_NUM         = 44,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic       newClock,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [5:0] num_sw,
  input  logic       busy,
  output logic       start_pulse,
  output logic [5:0] target,
  output logic       ready,
  output logic [1:0] err_code
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [31:0]      MAX_VAL  = 32'(MAX_NUM);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_ERR
  } state_e;

  logic            btnMeta_q;
  logic            btnSync_q;
  logic [5:0]      numMeta_q;
  logic [5:0]      numSync_q;

  logic [DB_W-1:0] dbCnt_q;
  logic [DB_W-1:0] dbCnt_d;
  logic            btnStable_q;
  logic            btnStable_d;
  logic            btnStableDly_q;
  logic            pressEvent;

  state_e          state_q;
  state_e          state_d;
  logic [5:0]      target_q;
  logic [5:0]      target_d;
  logic [1:0]      errCode_q;
  logic [1:0]      errCode_d;
  logic [ACK_W-1:0] ackCnt_q;
  logic [ACK_W-1:0] ackCnt_d;
  logic            startPulse_q;
  logic            startPulse_d;
  logic            ready_q;
  logic            ready_d;

  // Two-flop synchronizers bring the raw button and switches into newClock.
  always_ff @(posedge newClock or negedge rst) begin
    if (!rst) begin
      btnMeta_q <= 1'b0;
      btnSync_q <= 1'b0;
      numMeta_q <= '0;
      numSync_q <= '0;
    end else begin
      btnMeta_q <= start_btn;
      btnSync_q <= btnMeta_q;
      numMeta_q <= num_sw;
      numSync_q <= numMeta_q;
    end
  end

  // Debounce: a level change is accepted only after it has held for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back clears the count.
  always_comb begin
    dbCnt_d     = '0;
    btnStable_d = btnStable_q;
    if (btnSync_q != btnStable_q) begin
      if (dbCnt_q == DB_LAST) begin
        btnStable_d = btnSync_q;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  // Debounced level, its one-cycle delayed copy and the run counter.
  always_ff @(posedge newClock or negedge rst) begin
    if (!rst) begin
      dbCnt_q        <= '0;
      btnStable_q    <= 1'b0;
      btnStableDly_q <= 1'b0;
    end else begin
      dbCnt_q        <= dbCnt_d;
      btnStable_q    <= btnStable_d;
      btnStableDly_q <= btnStable_q;
    end
  end

  // Only the rising edge of the debounced button counts as a press.
  assign pressEvent = btnStable_q & ~btnStableDly_q;

  // Control FSM. The switch value is captured on the edge that enters CHECK
  // so target is already valid while CHECK range-checks it; later switch
  // movement cannot disturb either the check or the latched value.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    errCode_d = errCode_q;
    ackCnt_d  = ackCnt_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (pressEvent) begin
          state_d   = S_CHECK;
          target_d  = numSync_q;
          errCode_d = ERR_NONE;
        end
      end
      S_CHECK: begin
        if ({26'd0, target_q} > MAX_VAL) begin
          state_d   = S_ERR;
          errCode_d = ERR_RANGE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT_ACK;
        ackCnt_d = '0;
      end
      S_WAIT_ACK: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else if (ackCnt_q == ACK_LAST) begin
          state_d   = S_ERR;
          errCode_d = ERR_TIMEOUT;
        end else begin
          ackCnt_d = ackCnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // exactly with the state they describe.
  always_comb begin
    startPulse_d = (state_d == S_ISSUE);
    ready_d      = (state_d == S_IDLE) || (state_d == S_ERR);
  end

  // FSM state and output registers; reset truncates any pulse in flight.
  always_ff @(posedge newClock or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      errCode_q    <= ERR_NONE;
      ackCnt_q     <= '0;
      startPulse_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      errCode_q    <= errCode_d;
      ackCnt_q     <= ackCnt_d;
      startPulse_q <= startPulse_d;
      ready_q      <= ready_d;
    end
  end

  assign start_pulse = startPulse_q;
  assign target      = target_q;
  assign ready       = ready_q;
  assign err_code    = errCode_q;

endmodule

// File: tb/tb_start_conditioner.sv
// tb_start_conditioner: directed and randomized presses against a timing
// model expressed in edges relative to the first sample of a clean press.
module tb_start_conditioner;

  localparam int D    = 4;
  localparam int ACK  = 8;
  localparam int MAXN = 44;

  logic       newClock;
  logic       rst;
  logic       start_btn;
  logic [5:0] num_sw;
  logic       busy;
  logic       start_pulse;
  logic [5:0] target;
  logic       ready;
  logic [1:0] err_code;

  int assertCount    = 0;
  int failCount      = 0;
  int cycle          = 0;
  int pulseTotal     = 0;
  int lastPulseCycle = -1;

  start_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .MAX_NUM(MAXN),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .newClock(newClock),
    .rst(rst),
    .start_btn(start_btn),
    .num_sw(num_sw),
    .busy(busy),
    .start_pulse(start_pulse),
    .target(target),
    .ready(ready),
    .err_code(err_code)
  );

  // Free-running clock, period 10.
  initial begin
    newClock = 1'b0;
    forever #5 newClock = ~newClock;
  end

  // Edge index: value seen at a falling edge is the number of the last rising edge.
  always @(posedge newClock) cycle <= cycle + 1;

  // Pulse monitor samples on the falling edge, away from the active edge.
  always @(negedge newClock) begin
    if (start_pulse === 1'b1) begin
      pulseTotal++;
      lastPulseCycle = cycle;
    end
  end

  // Absolute time bound so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitUntil(input int t);
    while (cycle < t) @(negedge newClock);
  endtask

  // Model of one accepted press whose first sample is edge e0: CHECK at
  // e0+D+2, pulse during the cycle after e0+D+3; busy raised j cycles after
  // the pulse edge and held for L cycles (j > ACK means never raised).
  task automatic expectPress(input int num, input int e0, input int startPulses,
                             input int j, input int L, input bit repress);
    int  pE;
    bit  valid;
    pE    = e0 + D + 3;
    valid = (num <= MAXN);
    waitUntil(e0 + D + 1);
    checkOutput("ready_before_accept", 32'(ready), 32'd1);
    checkOutput("no_early_pulse", 32'(start_pulse), 32'd0);
    waitUntil(e0 + D + 2);
    checkOutput("target_latched", 32'(target), 32'(num));
    checkOutput("err_cleared_in_check", 32'(err_code), 32'd0);
    checkOutput("ready_in_check", 32'(ready), 32'd0);
    num_sw = 6'(num) ^ 6'h3F;
    waitUntil(pE);
    checkOutput("target_held", 32'(target), 32'(num));
    if (!valid) begin
      checkOutput("range_no_pulse", 32'(start_pulse), 32'd0);
      checkOutput("range_err", 32'(err_code), 32'd1);
      checkOutput("range_ready", 32'(ready), 32'd1);
      start_btn = 1'b0;
    end else begin
      checkOutput("pulse_high", 32'(start_pulse), 32'd1);
      checkOutput("pulse_err", 32'(err_code), 32'd0);
      checkOutput("pulse_ready", 32'(ready), 32'd0);
      start_btn = 1'b0;
      if (j > ACK) begin
        waitUntil(pE + ACK);
        checkOutput("ack_wait_err", 32'(err_code), 32'd0);
        checkOutput("ack_wait_ready", 32'(ready), 32'd0);
        waitUntil(pE + ACK + 1);
        checkOutput("timeout_err", 32'(err_code), 32'd2);
        checkOutput("timeout_ready", 32'(ready), 32'd1);
      end else begin
        waitUntil(pE + j);
        busy = 1'b1;
        if (repress) begin
          waitUntil(pE + j + 5);
          start_btn = 1'b1;
          waitUntil(pE + j + 14);
          start_btn = 1'b0;
        end
        waitUntil(pE + j + L);
        checkOutput("ready_while_busy", 32'(ready), 32'd0);
        busy = 1'b0;
        waitUntil(pE + j + L + 1);
        checkOutput("ready_after_done", 32'(ready), 32'd1);
        checkOutput("err_after_done", 32'(err_code), 32'd0);
      end
    end
    repeat (D + 4) @(negedge newClock);
    checkOutput("pulse_count", 32'(pulseTotal - startPulses), valid ? 32'd1 : 32'd0);
    if (valid) checkOutput("pulse_edge", 32'(lastPulseCycle - e0), 32'(D + 3));
  endtask

  // Set the switches, optionally bounce the button, then press and check.
  task automatic applyStimulus(input int num, input int j, input int L,
                               input bit repress, input bit bounce);
    int   e0;
    int   sp;
    logic [6:0] pattern;
    num_sw = 6'(num);
    repeat (3) @(negedge newClock);
    sp      = pulseTotal;
    pattern = 7'b1110110;
    if (bounce) begin
      for (int i = 6; i >= 0; i--) begin
        start_btn = pattern[i];
        @(negedge newClock);
      end
    end
    e0        = cycle + 1;
    start_btn = 1'b1;
    expectPress(num, e0, sp, j, L, repress);
  endtask

  initial begin
    int e0;
    int sp;
    int num;
    rst       = 1'b0;
    start_btn = 1'b0;
    num_sw    = '0;
    busy      = 1'b0;
    repeat (3) @(negedge newClock);
    checkOutput("reset_pulse", 32'(start_pulse), 32'd0);
    checkOutput("reset_target", 32'(target), 32'd0);
    checkOutput("reset_err", 32'(err_code), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge newClock);

    applyStimulus(5, 1, 3, 1'b0, 1'b0);
    applyStimulus(12, 1, 3, 1'b0, 1'b1);
    applyStimulus(45, 1, 3, 1'b0, 1'b0);
    applyStimulus(44, 0, 4, 1'b0, 1'b0);
    applyStimulus(0, 3, 2, 1'b0, 1'b0);
    applyStimulus(7, 2, 20, 1'b1, 1'b0);
    applyStimulus(20, ACK + 1, 0, 1'b0, 1'b0);
    applyStimulus(63, 1, 3, 1'b0, 1'b0);
    applyStimulus(30, ACK, 2, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      num = ($urandom_range(0, 3) == 0) ? int'($urandom_range(45, 63))
                                        : int'($urandom_range(0, 44));
      applyStimulus(num, int'($urandom_range(0, 10)), int'($urandom_range(2, 6)),
                    1'b0, 1'b0);
    end

    // Reset in WAIT_DONE with the button still held.
    num_sw = 6'd9;
    repeat (3) @(negedge newClock);
    sp        = pulseTotal;
    e0        = cycle + 1;
    start_btn = 1'b1;
    waitUntil(e0 + D + 3);
    checkOutput("pre_reset_pulse", 32'(start_pulse), 32'd1);
    busy = 1'b1;
    waitUntil(e0 + D + 6);
    checkOutput("pre_reset_busy_ready", 32'(ready), 32'd0);
    checkOutput("pre_reset_target", 32'(target), 32'd9);
    rst = 1'b0;
    #1;
    checkOutput("midrst_pulse", 32'(start_pulse), 32'd0);
    checkOutput("midrst_target", 32'(target), 32'd0);
    checkOutput("midrst_err", 32'(err_code), 32'd0);
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    busy = 1'b0;
    repeat (3) @(negedge newClock);
    checkOutput("held_rst_target", 32'(target), 32'd0);
    checkOutput("prior_pulse_count", 32'(pulseTotal - sp), 32'd1);
    rst = 1'b1;
    sp  = pulseTotal;
    e0  = cycle + 1;
    expectPress(9, e0, sp, 1, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
